// File: rtl/mult_arbiter.sv
// Round-robin scheduler sharing one parity-checked 16x16 signed multiplier
// between N_REQ clients; one operation in flight at a time.
module mult_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned IDW     = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      cli_req,
  input  logic [16*N_REQ-1:0]   cli_arg_a,
  input  logic [N_REQ-1:0]      cli_arg_a_parity,
  input  logic [16*N_REQ-1:0]   cli_arg_b,
  input  logic [N_REQ-1:0]      cli_arg_b_parity,
  output logic [N_REQ-1:0]      cli_ack,
  output logic [N_REQ-1:0]      cli_result_rdy,
  output logic [31:0]           cli_result,
  output logic                  cli_result_parity,
  output logic                  cli_parity_error,
  output logic                  cli_timeout,
  output logic                  mult_req,
  output logic [15:0]           mult_arg_a,
  output logic [15:0]           mult_arg_b,
  output logic                  mult_arg_a_parity,
  output logic                  mult_arg_b_parity,
  input  logic                  mult_ack,
  input  logic [31:0]           mult_result,
  input  logic                  mult_result_parity,
  input  logic                  mult_result_rdy,
  input  logic                  mult_arg_parity_error,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DELIVER = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [N_REQ-1:0] ack_d, rdy_d;
  logic [31:0]      result_d;
  logic             rpar_d, perr_d, to_d, mreq_d, busy_d;
  logic [15:0]      arg_a_d, arg_b_d;
  logic             arg_a_par_d, arg_b_par_d;
  logic [IDW-1:0]   grant_d;

  logic [IDW-1:0]   win, hi_idx, lo_idx;
  logic             hi_found;
  logic [15:0]      sel_a, sel_b;
  logic             sel_a_par, sel_b_par;

  // Round-robin pick: lowest requester above last_grant, else lowest overall.
  always_comb begin
    hi_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_a_par = 1'b0;
    sel_b_par = 1'b0;
    for (int j = int'(N_REQ) - 1; j >= 0; j--) begin
      if (cli_req[j]) begin
        lo_idx = IDW'(j);
        if (IDW'(j) > last_grant_q) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(j);
        end
      end
    end
    win = hi_found ? hi_idx : lo_idx;
    for (int j = 0; j < int'(N_REQ); j++) begin
      if (IDW'(j) == win) begin
        sel_a     = cli_arg_a[16*j +: 16];
        sel_b     = cli_arg_b[16*j +: 16];
        sel_a_par = cli_arg_a_parity[j];
        sel_b_par = cli_arg_b_parity[j];
      end
    end
  end

  // Next-state and next-output logic; outputs are loaded on state transitions.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    ack_d        = '0;
    rdy_d        = '0;
    result_d     = cli_result;
    rpar_d       = cli_result_parity;
    perr_d       = cli_parity_error;
    to_d         = cli_timeout;
    mreq_d       = mult_req;
    arg_a_d      = mult_arg_a;
    arg_b_d      = mult_arg_b;
    arg_a_par_d  = mult_arg_a_parity;
    arg_b_par_d  = mult_arg_b_parity;
    grant_d      = grant_id;

    case (state_q)
      S_IDLE: begin
        if (|cli_req) begin
          ack_d       = N_REQ'(1) << win;
          grant_d     = win;
          arg_a_d     = sel_a;
          arg_b_d     = sel_b;
          arg_a_par_d = sel_a_par;
          arg_b_par_d = sel_b_par;
          mreq_d      = 1'b1;
          cnt_d       = '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if ((state_q == S_ISSUE) && mult_ack && !mult_result_rdy) begin
          mreq_d  = 1'b0;
          state_d = S_WAIT;
        end
        if (mult_result_rdy && ((state_q == S_WAIT) || mult_ack)) begin
          mreq_d   = 1'b0;
          rdy_d    = N_REQ'(1) << grant_id;
          result_d = mult_result;
          rpar_d   = mult_result_parity;
          perr_d   = mult_arg_parity_error;
          to_d     = 1'b0;
          state_d  = S_DELIVER;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Abort: the client still gets a result pulse, flagged as timed out.
          mreq_d   = 1'b0;
          rdy_d    = N_REQ'(1) << grant_id;
          result_d = '0;
          rpar_d   = 1'b0;
          perr_d   = 1'b0;
          to_d     = 1'b1;
          state_d  = S_DELIVER;
        end
      end
      S_DELIVER: begin
        last_grant_d = grant_id;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      last_grant_q      <= IDW'(N_REQ - 1);
      cnt_q             <= '0;
      cli_ack           <= '0;
      cli_result_rdy    <= '0;
      cli_result        <= '0;
      cli_result_parity <= 1'b0;
      cli_parity_error  <= 1'b0;
      cli_timeout       <= 1'b0;
      mult_req          <= 1'b0;
      mult_arg_a        <= '0;
      mult_arg_b        <= '0;
      mult_arg_a_parity <= 1'b0;
      mult_arg_b_parity <= 1'b0;
      busy              <= 1'b0;
      grant_id          <= '0;
    end else begin
      state_q           <= state_d;
      last_grant_q      <= last_grant_d;
      cnt_q             <= cnt_d;
      cli_ack           <= ack_d;
      cli_result_rdy    <= rdy_d;
      cli_result        <= result_d;
      cli_result_parity <= rpar_d;
      cli_parity_error  <= perr_d;
      cli_timeout       <= to_d;
      mult_req          <= mreq_d;
      mult_arg_a        <= arg_a_d;
      mult_arg_b        <= arg_b_d;
      mult_arg_a_parity <= arg_a_par_d;
      mult_arg_b_parity <= arg_b_par_d;
      busy              <= busy_d;
      grant_id          <= grant_d;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed table, corner sequences and
// randomized ops against a round-robin / multiply reference model.
module tb_mult_arbiter;

  localparam int N = 4;
  localparam int TMO = 255;

  logic          clk, rst_n;
  logic [N-1:0]  cli_req;
  logic [16*N-1:0] cli_arg_a, cli_arg_b;
  logic [N-1:0]  cli_arg_a_parity, cli_arg_b_parity;
  logic [N-1:0]  cli_ack, cli_result_rdy;
  logic [31:0]   cli_result;
  logic          cli_result_parity, cli_parity_error, cli_timeout;
  logic          mult_req;
  logic [15:0]   mult_arg_a, mult_arg_b;
  logic          mult_arg_a_parity, mult_arg_b_parity;
  logic          mult_ack;
  logic [31:0]   mult_result;
  logic          mult_result_parity, mult_result_rdy, mult_arg_parity_error;
  logic          busy;
  logic [1:0]    grant_id;

  mult_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cli_req(cli_req),
    .cli_arg_a(cli_arg_a), .cli_arg_a_parity(cli_arg_a_parity),
    .cli_arg_b(cli_arg_b), .cli_arg_b_parity(cli_arg_b_parity),
    .cli_ack(cli_ack), .cli_result_rdy(cli_result_rdy),
    .cli_result(cli_result), .cli_result_parity(cli_result_parity),
    .cli_parity_error(cli_parity_error), .cli_timeout(cli_timeout),
    .mult_req(mult_req),
    .mult_arg_a(mult_arg_a), .mult_arg_b(mult_arg_b),
    .mult_arg_a_parity(mult_arg_a_parity), .mult_arg_b_parity(mult_arg_b_parity),
    .mult_ack(mult_ack), .mult_result(mult_result),
    .mult_result_parity(mult_result_parity), .mult_result_rdy(mult_result_rdy),
    .mult_arg_parity_error(mult_arg_parity_error),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] ca [N];
  logic [15:0] cb [N];
  logic        cpa [N];
  logic        cpb [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cli_arg_a[16*i +: 16] = ca[i];
      cli_arg_b[16*i +: 16] = cb[i];
      cli_arg_a_parity[i]   = cpa[i];
      cli_arg_b_parity[i]   = cpb[i];
    end
  end

  int checks = 0;
  int errors = 0;
  int model_last;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] a;
    logic [15:0] b;
    bit          bad_pa;
    int          ack_dly;
    int          rdy_gap;
    int          exp_w;
    logic [31:0] exp_res;
    bit          exp_perr;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
    int ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    return 32'(ia * ib);
  endfunction

  // Reference arbitration: first requester after the last served one, wrapping.
  function automatic int pick(input logic [3:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [32:0] model_res(input int w);
    bit bad;
    bad = (cpa[w] != ^ca[w]) || (cpb[w] != ^cb[w]);
    return {bad, bad ? 32'h0 : prod(ca[w], cb[w])};
  endfunction

  // Multiplier stand-in: checks argument parity and zeroes the result on error.
  task automatic drive_result();
    bit bad;
    bad = (mult_arg_a_parity != ^mult_arg_a) || (mult_arg_b_parity != ^mult_arg_b);
    mult_result           = bad ? 32'h0 : prod(mult_arg_a, mult_arg_b);
    mult_result_parity    = ^mult_result;
    mult_arg_parity_error = bad;
    mult_result_rdy       = 1'b1;
  endtask

  task automatic clear_mult();
    mult_ack              = 1'b0;
    mult_result_rdy       = 1'b0;
    mult_arg_parity_error = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, cli_ack, 0);
    check({tag, "_rdy"}, cli_result_rdy, 0);
    check({tag, "_res"}, cli_result, 0);
    check({tag, "_flags"}, {cli_result_parity, cli_parity_error, cli_timeout}, 0);
    check({tag, "_mreq"}, mult_req, 0);
    check({tag, "_args"}, {mult_arg_a, mult_arg_b}, 0);
    check({tag, "_busy_gid"}, {busy, grant_id}, 0);
  endtask

  // One full operation starting from IDLE with cli_req already driven.
  task automatic run_op(input int w, input int ack_dly, input int rdy_gap, input bit no_ack,
                        input logic [31:0] exp_res_in, input bit exp_perr_in);
    logic [31:0] exp_res;
    bit          exp_perr, exp_to;
    int          cnt;
    exp_res  = exp_res_in;
    exp_perr = exp_perr_in;
    exp_to   = 1'b0;
    tick();
    check("ack", cli_ack, 32'(1 << w));
    check("grant_id", grant_id, w);
    check("mult_req_up", {busy, mult_req}, 2'b11);
    check("arg_a", mult_arg_a, ca[w]);
    check("arg_b", mult_arg_b, cb[w]);
    check("arg_par", {mult_arg_a_parity, mult_arg_b_parity}, {cpa[w], cpb[w]});
    if (no_ack) begin
      cnt = 0;
      while (mult_req && cnt < 400) begin
        cnt++;
        tick();
      end
      check("timeout_len", cnt, TMO);
      exp_res  = 0;
      exp_perr = 1'b0;
      exp_to   = 1'b1;
    end else begin
      repeat (ack_dly) tick();
      check("mult_req_hold", mult_req, 1);
      mult_ack = 1'b1;
      if (rdy_gap == 0) drive_result();
      tick();
      clear_mult();
      check("mult_req_drop", mult_req, 0);
      if (rdy_gap > 0) begin
        repeat (rdy_gap - 1) tick();
        check("no_early_rdy", cli_result_rdy, 0);
        drive_result();
        tick();
        clear_mult();
      end
    end
    check("rdy", cli_result_rdy, 32'(1 << w));
    check("result", cli_result, exp_res);
    check("flags", {cli_result_parity, cli_parity_error, cli_timeout}, {^exp_res, exp_perr, exp_to});
    check("ack_once", cli_ack, 0);
    tick();
    check("rdy_pulse", cli_result_rdy, 0);
    check("hold", {cli_result, cli_parity_error, cli_timeout}, {exp_res, exp_perr, exp_to});
    check("idle", busy, 0);
    model_last = w;
  endtask

  task automatic rand_args();
    for (int i = 0; i < N; i++) begin
      ca[i]  = 16'($urandom);
      cb[i]  = 16'($urandom);
      cpa[i] = ^ca[i];
      cpb[i] = ^cb[i];
    end
  endtask

  initial begin
    logic [32:0] m;
    logic [3:0]  rq;
    int          w;

    tbl[0] = '{4'b0100, 16'd3,     16'hFFFC, 1'b0, 2, 1, 2, 32'hFFFFFFF4, 1'b0};
    tbl[1] = '{4'b0010, 16'd5,     16'd7,    1'b1, 0, 0, 1, 32'h00000000, 1'b1};
    tbl[2] = '{4'b1111, 16'hFFFE,  16'hFFFD, 1'b0, 1, 3, 2, 32'h00000006, 1'b0};
    tbl[3] = '{4'b1011, 16'd100,   16'hFF9C, 1'b0, 0, 2, 3, 32'hFFFFD8F0, 1'b0};
    tbl[4] = '{4'b0011, 16'h7FFF,  16'h7FFF, 1'b0, 3, 1, 0, 32'h3FFF0001, 1'b0};
    tbl[5] = '{4'b0001, 16'h8000,  16'h8000, 1'b0, 0, 1, 0, 32'h40000000, 1'b0};
    tbl[6] = '{4'b1001, 16'd1,     16'hFFFF, 1'b1, 1, 2, 3, 32'h00000000, 1'b1};

    rst_n = 1'b0;
    cli_req = '0;
    mult_result = '0;
    mult_result_parity = 1'b0;
    clear_mult();
    rand_args();
    model_last = N - 1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Directed table.
    foreach (tbl[i]) begin
      rand_args();
      ca[tbl[i].exp_w]  = tbl[i].a;
      cb[tbl[i].exp_w]  = tbl[i].b;
      cpa[tbl[i].exp_w] = (^tbl[i].a) ^ tbl[i].bad_pa;
      cpb[tbl[i].exp_w] = ^tbl[i].b;
      cli_req = tbl[i].req;
      run_op(tbl[i].exp_w, tbl[i].ack_dly, tbl[i].rdy_gap, 1'b0, tbl[i].exp_res, tbl[i].exp_perr);
      cli_req = '0;
    end

    // Multiplier never acks: timeout, then a normal op clears the flag.
    rand_args();
    ca[0] = 16'd2; cb[0] = 16'd3; cpa[0] = ^ca[0]; cpb[0] = ^cb[0];
    cli_req = 4'b0001;
    run_op(0, 0, 0, 1'b1, 32'h0, 1'b0);
    run_op(0, 1, 1, 1'b0, 32'd6, 1'b0);
    cli_req = '0;

    // Reset while waiting for the result.
    rand_args();
    cli_req = 4'b0100;
    tick();
    check("mid_ack", cli_ack, 4'b0100);
    cli_req = '0;
    mult_ack = 1'b1;
    tick();
    clear_mult();
    check("mid_wait", {busy, mult_req}, 2'b10);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) begin
      tick();
      check("midrst_no_rdy", cli_result_rdy, 0);
    end
    rst_n = 1'b1;
    model_last = N - 1;

    // All clients requesting continuously: strict 0,1,2,3 rotation.
    cli_req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      m = model_res(k % N);
      run_op(k % N, k % 3, (k + 1) % 3, 1'b0, m[31:0], m[32]);
    end
    cli_req = '0;

    // Randomized ops against the reference model.
    for (int k = 0; k < 40; k++) begin
      rand_args();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) cpa[i] = ~cpa[i];
        if ($urandom_range(0, 7) == 0) cpb[i] = ~cpb[i];
      end
      rq = 4'($urandom_range(1, 15));
      w = pick(rq, model_last);
      m = model_res(w);
      cli_req = rq;
      run_op(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, m[31:0], m[32]);
      cli_req = '0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
